rmst_to_ram_tile: RTL and testbench
===================================

# rmst_to_ram_tile

Load-side counterpart of the tile store path. Fetches `iolen` 32-bit words from external memory, starting at byte address `raddr`, through the Avalon read master, and writes them into the on-chip tile RAM at word addresses 0..iolen-1. Read commands are issued in bursts of at most BLEN words. Each XDW-bit beat popped from the read-master FIFO is unpacked into WCNT sequential RAM writes.

## Interface
- AW, 12, tile RAM word-address width and `iolen` width
- CW, 6, read-length width in bytes; must hold BLEN*4
- DW, 32, RAM word width
- XAW, 32, external byte-address width
- XDW, 128, read-master data width
- WCNT, XDW/DW, words per beat
- BLEN, 8, maximum words per read command
- MAX_PENDING, 16, cap on outstanding words, in bursts: issued minus written ≤ MAX_PENDING*BLEN
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rmst_fixed_location  out  1  tied to 0
- rmst_read_base  out  XAW  byte address of the current command
- rmst_read_length  out  CW  byte length of the current command
- rmst_go  out  1  one-cycle command pulse
- rmst_done  in  1  read master idle (high) or busy (low)
- rmst_user_read_buffer  out  1  FIFO pop; acknowledges the show-ahead data
- rmst_user_buffer_data  in  XDW  FIFO head; valid while available=1
- rmst_user_data_available  in  1  FIFO non-empty
- config_done  in  1  latch parameters
- param_iolen  in  AW  word count
- param_raddr  in  XAW  external byte base
- load_data_start  in  1  start pulse
- load_data_done  out  1  level; transfer complete
- rmst_wr_ena  out  1  RAM write enable
- rmst_wr_addr  out  AW  RAM word address
- rmst_wr_data  out  DW  RAM write data

## Operation
- **Reset values.** Every output and register resets to 0, and the FSM resets to IDLE.
- **Parameter latch.** `config_done` latches `iolen`, `raddr`, `rd_len=iolen` and `rmst_read_base=raddr`, and clears `load_data_done`. It is honoured only in IDLE; it is ignored while busy.
- **IDLE.**
  - `load_data_start` with `iolen≠0` clears the issued count, written count and unpacker, then moves to CMD.
  - A start with `iolen=0` is ignored.
  - A start while not in IDLE is ignored.
- **CMD.**
  - If `rd_len=0`, go to FLUSH.
  - Otherwise, when `rmst_done=1` and (issued − written) + BLEN ≤ MAX_PENDING*BLEN, register `rmst_go=1` for one cycle, then go to WAIT.
  - In the same cycle:
    - `burst = min(rd_len, BLEN)`
    - `rmst_read_length = burst*4`
    - `rd_len -= burst`
    - issued += burst
- **WAIT.** Ignore `rmst_done` for one cycle (the master's done may still read high). Then return to CMD once `rmst_done=1`. The next command's base is the previous base + the previous length.
- **FLUSH.** When written = `iolen` and `rmst_done=1`, set `load_data_done=1` and go to IDLE. `load_data_done` holds until the next accepted `load_data_start` or `config_done`.
- **Unpacker** (runs independently of the FSM whenever not IDLE):
  - Holds one beat and a word index `k` in 0..WCNT-1.
  - Pops (`rmst_user_read_buffer=1`) when `rmst_user_data_available=1` and either no beat is held or the held beat is on its final write this cycle.
  - Word `k` = `beat[DW*k +: DW]`, least-significant word first.
  - Each held cycle writes one word: `rmst_wr_ena=1`, `rmst_wr_addr=written`, then written += 1.
  - A beat's final write is at k=WCNT-1 or at written=iolen-1, whichever comes first. Words past `iolen` in the last beat are discarded.
- **Arithmetic.** Address math is XAW-bit and wraps modulo 2^XAW. Counts are AW-bit; `iolen ≤ 2^AW-1`.
- **Reset mid-transfer.** All state returns to reset values on the next edge. Partially written RAM content is not retracted.

## Timing
- `load_data_start` sampled at edge N, with `rmst_done=1`: `rmst_go` is high during cycle N+2 (IDLE→CMD at N, go registered at N+1). `rmst_read_base` and `rmst_read_length` are stable while `rmst_go=1`.
- Minimum spacing between `rmst_go` pulses is 3 cycles.
- Pop in cycle P gives the first write in P+1, then one write per cycle. Sustained rate is 1 word/cycle while the FIFO stays non-empty.
- `rmst_wr_addr`, `rmst_wr_data` and `rmst_wr_ena` are registered and change together.
- `load_data_done` rises at the earliest 1 cycle after the last write.
- Simultaneous pop and final write of the held beat: the new beat's word 0 is written in the next cycle, with no bubble.

## Test plan
1. iolen=8, raddr=0x1000, FIFO always available, data word i = 0xA000+i -> one go (base 0x1000, length 32); writes at addresses 0..7 with matching data, 8 consecutive cycles; done.
2. iolen=20, raddr=0x1000 -> three gos: (0x1000, 32), (0x1020, 32), (0x1040, 16); 20 writes; `load_data_done=1` only after `rmst_done` is high and all writes complete.
3. iolen=6 -> second beat writes only addresses 4,5; its words 2,3 are discarded; exactly 6 writes total.
4. `rmst_user_data_available` toggled 1,0,0,1 pseudo-randomly -> writes pause during gaps; no duplicated or skipped addresses; the data sequence is intact.
5. `rmst_done` held low for 50 cycles after the first go -> no further go until it rises, then next go ≥1 cycle later. With MAX_PENDING=1 and data withheld, no second go until 8 words are written.
6. rst asserted mid-transfer (after 5 writes of iolen=20) -> all outputs 0 next cycle. A new config_done and start then reproduce scenario 2 exactly. `load_data_start` while busy has no effect.

Source files
------------

// File: rtl/rmst_to_ram_tile.sv
// rmst_to_ram_tile: streams iolen words from external memory into tile RAM
// through the Avalon read master, in bursts of up to BLEN words.
module rmst_to_ram_tile #(
  parameter int AW          = 12,
  parameter int CW          = 6,
  parameter int DW          = 32,
  parameter int XAW         = 32,
  parameter int XDW         = 128,
  parameter int WCNT        = XDW / DW,
  parameter int BLEN        = 8,
  parameter int MAX_PENDING = 16
) (
  input  logic           clk,
  input  logic           rst,
  output logic           rmst_fixed_location,
  output logic [XAW-1:0] rmst_read_base,
  output logic [CW-1:0]  rmst_read_length,
  output logic           rmst_go,
  input  logic           rmst_done,
  output logic           rmst_user_read_buffer,
  input  logic [XDW-1:0] rmst_user_buffer_data,
  input  logic           rmst_user_data_available,
  input  logic           config_done,
  input  logic [AW-1:0]  param_iolen,
  input  logic [XAW-1:0] param_raddr,
  input  logic           load_data_start,
  output logic           load_data_done,
  output logic           rmst_wr_ena,
  output logic [AW-1:0]  rmst_wr_addr,
  output logic [DW-1:0]  rmst_wr_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam int KW = (WCNT > 1) ? $clog2(WCNT) : 1;
  localparam logic [31:0] PEND_MAX = 32'(MAX_PENDING * BLEN);

  logic [2:0]     state;
  logic [AW-1:0]  iolen;
  logic [XAW-1:0] raddr;
  logic [AW-1:0]  rd_len;
  logic [AW-1:0]  issued;
  logic [AW-1:0]  written;
  logic [AW-1:0]  burst;
  logic [AW-1:0]  outstanding;
  logic [31:0]    pend;
  logic           can_issue;
  logic           busy;
  logic           start_ok;

  logic [XDW-1:0] beat;
  logic           held;
  logic [KW-1:0]  k;
  logic [DW-1:0]  cur_word;
  logic           last_word;
  logic           final_wr;
  logic           pop;

  assign rmst_fixed_location = 1'b0;

  assign busy     = (state != S_IDLE);
  assign start_ok = !busy && !config_done &&
                    load_data_start && (iolen != '0);

  assign burst = (rd_len < AW'(BLEN)) ? rd_len : AW'(BLEN);
  assign outstanding = issued - written;
  assign pend = 32'(outstanding) + 32'(BLEN);
  assign can_issue = rmst_done && (pend <= PEND_MAX);

  assign last_word = (written == iolen - AW'(1));
  assign final_wr  = held && ((k == KW'(WCNT - 1)) || last_word);
  assign cur_word  = beat[DW*int'(k) +: DW];

  // Never pop beyond the words this transfer still needs.
  assign pop = busy && rmst_user_data_available &&
               (held ? (final_wr && !last_word)
                     : (written != iolen));
  assign rmst_user_read_buffer = pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      iolen            <= '0;
      raddr            <= '0;
      rd_len           <= '0;
      issued           <= '0;
      rmst_read_base   <= '0;
      rmst_read_length <= '0;
      rmst_go          <= 1'b0;
      load_data_done   <= 1'b0;
    end else begin
      rmst_go <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (config_done) begin
            iolen          <= param_iolen;
            raddr          <= param_raddr;
            rd_len         <= param_iolen;
            rmst_read_base <= param_raddr;
            load_data_done <= 1'b0;
          end else if (start_ok) begin
            issued         <= '0;
            rd_len         <= iolen;
            rmst_read_base <= raddr;
            load_data_done <= 1'b0;
            state          <= S_CMD;
          end
        end
        S_CMD: begin
          if (rd_len == '0) begin
            state <= S_FLUSH;
          end else if (can_issue) begin
            rmst_go          <= 1'b1;
            rmst_read_length <= CW'({burst, 2'b00});
            rd_len           <= rd_len - burst;
            issued           <= issued + burst;
            state            <= S_WAIT;
          end
        end
        // done may still read high right after go
        S_WAIT: state <= S_HOLD;
        S_HOLD: begin
          if (rmst_done) begin
            rmst_read_base <= rmst_read_base +
                              XAW'(rmst_read_length);
            state          <= S_CMD;
          end
        end
        S_FLUSH: begin
          if ((written == iolen) && rmst_done) begin
            load_data_done <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat         <= '0;
      held         <= 1'b0;
      k            <= '0;
      written      <= '0;
      rmst_wr_ena  <= 1'b0;
      rmst_wr_addr <= '0;
      rmst_wr_data <= '0;
    end else begin
      rmst_wr_ena <= 1'b0;
      if (start_ok) begin
        held    <= 1'b0;
        k       <= '0;
        written <= '0;
      end else if (busy) begin
        if (held) begin
          rmst_wr_ena  <= 1'b1;
          rmst_wr_addr <= written;
          rmst_wr_data <= cur_word;
          written      <= written + AW'(1);
          k            <= k + KW'(1);
          if (final_wr) begin
            held <= 1'b0;
            k    <= '0;
          end
        end
        if (pop) begin
          beat <= rmst_user_buffer_data;
          held <= 1'b1;
          k    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rmst_to_ram_tile.sv
// tb_rmst_to_ram_tile: random read-master/FIFO emulation with a
// word-stream reference model of the expected commands and RAM writes.
module tb_rmst_to_ram_tile;

  localparam int AW  = 12;
  localparam int CW  = 6;
  localparam int DW  = 32;
  localparam int XAW = 32;
  localparam int XDW = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           rmst_fixed_location;
  logic [XAW-1:0] rmst_read_base;
  logic [CW-1:0]  rmst_read_length;
  logic           rmst_go;
  logic           rmst_done;
  logic           rmst_user_read_buffer;
  logic [XDW-1:0] rmst_user_buffer_data;
  logic           rmst_user_data_available;
  logic           config_done;
  logic [AW-1:0]  param_iolen;
  logic [XAW-1:0] param_raddr;
  logic           load_data_start;
  logic           load_data_done;
  logic           rmst_wr_ena;
  logic [AW-1:0]  rmst_wr_addr;
  logic [DW-1:0]  rmst_wr_data;

  always #5 clk = ~clk;

  rmst_to_ram_tile dut (
    .clk                      (clk),
    .rst                      (rst),
    .rmst_fixed_location      (rmst_fixed_location),
    .rmst_read_base           (rmst_read_base),
    .rmst_read_length         (rmst_read_length),
    .rmst_go                  (rmst_go),
    .rmst_done                (rmst_done),
    .rmst_user_read_buffer    (rmst_user_read_buffer),
    .rmst_user_buffer_data    (rmst_user_buffer_data),
    .rmst_user_data_available (rmst_user_data_available),
    .config_done              (config_done),
    .param_iolen              (param_iolen),
    .param_raddr              (param_raddr),
    .load_data_start          (load_data_start),
    .load_data_done           (load_data_done),
    .rmst_wr_ena              (rmst_wr_ena),
    .rmst_wr_addr             (rmst_wr_addr),
    .rmst_wr_data             (rmst_wr_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] fifo[$];
  int busy_cnt = 0;
  int beats_left = 0;
  int hold_low = 0;
  logic [31:0] cur_addr;
  logic [31:0] seed;
  bit gaps = 0;
  bit withhold = 0;

  int run_n;
  logic [31:0] run_raddr;
  int nwr, ngo, issued_w, nexp;
  int last_go, first_wr, last_wr, done_cyc;
  bit prev_done = 0;
  logic [31:0] exp_base[$];
  logic [5:0]  exp_len[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [127:0] beat_at(input logic [31:0] a);
    logic [127:0] b;
    for (int w = 0; w < 4; w++)
      b[32*w +: 32] = word_at(a + 32'(4 * w));
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (hold_low > 0) hold_low--;
    if (busy_cnt > 0) begin
      if (beats_left > 0) begin
        fifo.push_back(beat_at(cur_addr));
        cur_addr += 32'd16;
        beats_left--;
      end
      busy_cnt--;
    end
    rmst_done = (busy_cnt == 0) && (hold_low == 0);
    rmst_user_data_available = (fifo.size() > 0) && !withhold &&
                               (!gaps || ($urandom_range(0, 2) != 0));
    rmst_user_buffer_data = (fifo.size() > 0) ? fifo[0] : '0;
    #1;
    if (rmst_user_read_buffer) begin
      chk("pop_avail", rmst_user_data_available, 1);
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    if (rmst_go) begin
      ngo++;
      if (last_go >= 0) chk("go_gap", (cyc - last_go) >= 3, 1);
      last_go = cyc;
      if (exp_base.size() == 0) begin
        chk("go_extra", ngo, nexp);
      end else begin
        chk("go_base", rmst_read_base, exp_base.pop_front());
        chk("go_len", rmst_read_length, exp_len.pop_front());
      end
      issued_w += int'(rmst_read_length) / 4;
      beats_left = (int'(rmst_read_length) / 4 + 3) / 4;
      busy_cnt = beats_left + $urandom_range(1, 3);
      cur_addr = rmst_read_base;
    end
    if (rmst_wr_ena) begin
      if (nwr >= run_n) begin
        chk("wr_count", nwr + 1, run_n);
      end else begin
        chk("wr_addr", rmst_wr_addr, nwr);
        chk("wr_data", rmst_wr_data,
            word_at(run_raddr + 32'(4 * nwr)));
      end
      if (nwr == 0) first_wr = cyc;
      last_wr = cyc;
      nwr++;
    end
    if (load_data_done && !prev_done) done_cyc = cyc;
    prev_done = load_data_done;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_go"}, rmst_go, 0);
    chk({tag, "_wr_ena"}, rmst_wr_ena, 0);
    chk({tag, "_wr_addr"}, rmst_wr_addr, 0);
    chk({tag, "_wr_data"}, rmst_wr_data, 0);
    chk({tag, "_done"}, load_data_done, 0);
    chk({tag, "_base"}, rmst_read_base, 0);
    chk({tag, "_len"}, rmst_read_length, 0);
    chk({tag, "_pop"}, rmst_user_read_buffer, 0);
    chk({tag, "_fixed"}, rmst_fixed_location, 0);
  endtask

  task automatic run(input int n, input logic [31:0] ra, input bit g,
                     input int wh, input bit long_low, input bit poke,
                     input int rst_after, input bit consec);
    int rem, bl, st, g1;
    logic [31:0] b;
    bit lat_done, lowed, gap_done, poked;
    run_n = n; run_raddr = ra; gaps = g;
    nwr = 0; ngo = 0; issued_w = 0;
    last_go = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
    lat_done = 0; lowed = 0; gap_done = 0; poked = 0; g1 = 0;
    exp_base.delete(); exp_len.delete();
    rem = n; b = ra;
    while (rem > 0) begin
      bl = (rem < 8) ? rem : 8;
      exp_base.push_back(b);
      exp_len.push_back(6'(bl * 4));
      b += 32'(bl * 4);
      rem -= bl;
    end
    nexp = exp_base.size();
    config_done = 1; param_iolen = AW'(n); param_raddr = ra;
    tick();
    config_done = 0;
    chk("cfg_done_clr", load_data_done, 0);
    load_data_start = 1;
    st = cyc;
    tick();
    load_data_start = 0;
    withhold = (wh > 0);
    for (int c = 0; c < 4000 && !load_data_done; c++) begin
      tick();
      if (ngo >= 1 && !lat_done) begin
        lat_done = 1;
        chk("go_lat", last_go - st, 2);
      end
      if (long_low && ngo == 1 && !lowed) begin
        lowed = 1; hold_low = 50; g1 = last_go;
      end
      if (long_low && lowed && ngo == 2 && !gap_done) begin
        gap_done = 1;
        chk("done_low_gap", (last_go - g1) > 50, 1);
      end
      if (poke && ngo == 1 && !poked) begin
        poked = 1;
        load_data_start = 1; config_done = 1;
        param_iolen = 12'd3; param_raddr = '0;
        tick();
        load_data_start = 0; config_done = 0;
        param_iolen = AW'(n); param_raddr = ra;
      end
      if (wh > 0 && c == wh) begin
        chk("pend_cap", issued_w, 128);
        withhold = 0;
      end
      if (rst_after > 0 && nwr == rst_after) begin
        rst = 1;
        tick();
        rst = 0;
        check_zero("midrst");
        fifo.delete();
        busy_cnt = 0; beats_left = 0; hold_low = 0;
        rmst_done = 1;
        return;
      end
    end
    chk("done", load_data_done, 1);
    chk("nwr", nwr, n);
    chk("ngo", ngo, nexp);
    chk("done_after_wr", done_cyc > last_wr, 1);
    if (consec) chk("consec", last_wr - first_wr, n - 1);
  endtask

  initial begin
    seed = $urandom();
    rst = 1; rmst_done = 1;
    rmst_user_data_available = 0; rmst_user_buffer_data = '0;
    config_done = 0; param_iolen = '0; param_raddr = '0;
    load_data_start = 0;
    tick();
    tick();
    check_zero("reset");
    rst = 0;
    tick();

    run(8, 32'h1000, 0, 0, 0, 0, 0, 1);
    run(20, 32'h1000, 0, 0, 0, 0, 0, 0);
    run(6, 32'h0000_2340, 0, 0, 0, 0, 0, 0);
    run(37, $urandom() & 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0);
    run(20, 32'h0000_8000, 0, 0, 1, 0, 0, 0);
    run(200, 32'h0001_0000, 0, 300, 0, 0, 0, 0);
    run(20, 32'hFFFF_FFE0, 1, 0, 0, 0, 0, 0);
    run(20, 32'h1000, 0, 0, 0, 1, 5, 0);
    run(20, 32'h1000, 0, 0, 0, 1, 0, 0);

    run_n = 0; ngo = 0; nwr = 0; nexp = 0; last_go = -1;
    exp_base.delete(); exp_len.delete();
    config_done = 1; param_iolen = '0; param_raddr = 32'h4000;
    tick();
    config_done = 0;
    load_data_start = 1;
    tick();
    load_data_start = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("zero_len_go", ngo, 0);
    chk("zero_len_done", load_data_done, 0);

    for (int i = 0; i < 6; i++)
      run($urandom_range(1, 70), $urandom() & 32'hFFFF_FFFC,
          1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
